// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and width-sized constants for the RV32M multiply/divide unit.
// The constant helpers return 64-bit values; callers cast them down to their own XLEN (XLEN <= 64).
package muldiv_pkg;
    typedef enum logic [2:0] {
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_e;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX, S_DONE} state_e;
    function automatic logic [63:0] min_neg(input int w);
        return 64'(1) << (w - 1);
    endfunction
    function automatic logic [63:0] all_ones(input int w);
        return (64'(1) << w) - 64'(1);
    endfunction
endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] val_o
);
    assign val_o = neg_i ? -val_i : val_i;
endmodule

// File: rtl/muldiv_r32m.sv
// muldiv_r32m: iterative RV32M multiply/divide unit, one bit per cycle, with valid/ready handshakes,
// pipeline kill and a pass-through destination tag.
module muldiv_r32m
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             kill_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             busy_o
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MINN = XLEN'(min_neg(XLEN));
    localparam logic [XLEN-1:0] ONES = XLEN'(all_ones(XLEN));

    state_e              state_q;
    op_e                 op_q;
    logic [CW-1:0]       cnt_q;
    logic [TAG_W-1:0]    tag_q;
    logic                neg_q, rneg_q, out_valid_q;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     b_q, result_q;

    op_e               op_in;
    logic              a_neg, b_neg, fast;
    logic [XLEN-1:0]   a_abs, b_abs, fast_res, rfix, fix_res;
    logic [XLEN:0]     msum, dtrial;
    logic [2*XLEN-1:0] pfix;

    assign op_in = op_e'(op_i);
    assign a_neg = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a_i[XLEN-1];
    assign b_neg = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && b_i[XLEN-1];

    muldiv_signfix #(.W(XLEN)) u_abs_a (.val_i(a_i), .neg_i(a_neg), .val_o(a_abs));
    muldiv_signfix #(.W(XLEN)) u_abs_b (.val_i(b_i), .neg_i(b_neg), .val_o(b_abs));

    // Divide by zero and signed overflow bypass the iteration and finish straight away.
    assign fast = op_i[2] && (b_i == '0 || ((op_in inside {OP_DIV, OP_REM}) && a_i == MINN && b_i == ONES));
    assign fast_res = (b_i == '0) ? (op_i[1] ? a_i : ONES) : (op_i[1] ? '0 : a_i);

    // Multiply: add multiplicand into the upper half when the lsb is set, then shift right.
    // Divide: shift remainder:quotient left and subtract the divisor when it fits.
    assign msum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    assign dtrial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    assign acc_d  = op_q[2] ? (dtrial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                            : {dtrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                            : {msum, acc_q[XLEN-1:1]};

    // Negating the whole remainder:quotient pair yields the negated quotient in the low half.
    muldiv_signfix #(.W(2*XLEN)) u_fix_p (.val_i(acc_q), .neg_i(neg_q), .val_o(pfix));
    muldiv_signfix #(.W(XLEN)) u_fix_r (.val_i(acc_q[2*XLEN-1:XLEN]), .neg_i(rneg_q), .val_o(rfix));

    assign fix_res = (op_q == OP_MUL) ? pfix[XLEN-1:0]
                   : !op_q[2]         ? pfix[2*XLEN-1:XLEN]
                   : op_q[1]          ? rfix
                   :                    pfix[XLEN-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MUL;
            cnt_q       <= '0;
            tag_q       <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            acc_q       <= '0;
            b_q         <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else if (kill_i) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (in_valid_i) begin
                    op_q    <= op_in;
                    tag_q   <= tag_i;
                    neg_q   <= a_neg ^ b_neg;
                    rneg_q  <= a_neg;
                    acc_q   <= {{XLEN{1'b0}}, a_abs};
                    b_q     <= b_abs;
                    cnt_q   <= '0;
                    state_q <= fast ? S_DONE : S_BUSY;
                    if (fast) begin
                        result_q    <= fast_res;
                        out_valid_q <= 1'b1;
                    end
                end
                S_BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1)) state_q <= S_FIX;
                end
                S_FIX: begin
                    result_q    <= fix_res;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: if (out_ready_i) begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q == S_IDLE) && rst_ni;
    assign busy_o      = (state_q == S_BUSY) || (state_q == S_FIX);
    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign out_tag_o   = tag_q;
endmodule

// File: tb/tb_muldiv_r32m.sv
// tb_muldiv_r32m: self-checking bench for muldiv_r32m against a 64-bit arithmetic reference model.
module tb_muldiv_r32m;
    logic clk = 1'b0, rst_n = 1'b1, in_valid = 1'b0, kill = 1'b0, out_ready = 1'b0;
    logic [2:0] op = '0;
    logic [31:0] a = '0, b = '0;
    logic [4:0] tag = '0;
    logic in_ready, out_valid, busy;
    logic [31:0] result;
    logic [4:0] out_tag;
    int passed = 0, total = 0;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a, b, exp;
        logic [5:0]  lat;
    } vec_t;

    localparam vec_t DIR [15] = '{
        '{3'd1, 32'h00000002, 32'hFFFFFFFC, 32'hFFFFFFFF, 6'd34},
        '{3'd3, 32'h00000002, 32'hFFFFFFFC, 32'h00000001, 6'd34},
        '{3'd2, 32'hFFFFFFFE, 32'h00000004, 32'hFFFFFFFF, 6'd34},
        '{3'd2, 32'h00000002, 32'hFFFFFFFC, 32'h00000001, 6'd34},
        '{3'd4, 32'd9, 32'd4, 32'd2, 6'd34},
        '{3'd6, 32'd9, 32'd4, 32'd1, 6'd34},
        '{3'd4, 32'hFFFFFFF7, 32'd4, 32'hFFFFFFFE, 6'd34},
        '{3'd6, 32'hFFFFFFF7, 32'd4, 32'hFFFFFFFF, 6'd34},
        '{3'd4, 32'hFFFFFFB2, 32'hFFFFFC7B, 32'h00000000, 6'd34},
        '{3'd6, 32'hFFFFFFB2, 32'hFFFFFC7B, 32'hFFFFFFB2, 6'd34},
        '{3'd5, 32'hFFFFFFFE, 32'd2, 32'h7FFFFFFF, 6'd34},
        '{3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 6'd1},
        '{3'd7, 32'd5, 32'd0, 32'd5, 6'd1},
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 6'd1},
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 6'd1}
    };

    always #5 clk = ~clk;

    muldiv_r32m #(.XLEN(32), .TAG_W(5)) dut (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .a_i(a), .b_i(b), .tag_i(tag), .kill_i(kill),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
        .out_tag_o(out_tag), .busy_o(busy)
    );

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, ux, uy, p, q, r;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        if (!o[2]) begin
            p = (o == 3'd3) ? ux * uy : (o == 3'd2) ? sx * uy : sx * sy;
            return (o == 3'd0) ? p[31:0] : p[63:32];
        end
        if (y == 32'd0) return o[1] ? x : 32'hFFFFFFFF;
        q = o[0] ? ux / uy : sx / sy;
        r = o[0] ? ux % uy : sx % sy;
        return o[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] t,
                         output logic [31:0] res, output logic [4:0] rtag, output int lat);
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y; tag = t;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom; tag = 5'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (lat < 100 && !out_valid);
        res = result;
        rtag = out_tag;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        total++; if (result !== 32'd0) $display("FAIL reset_result got %h want 0", result); else passed++;
        total++; if (out_tag !== 5'd0) $display("FAIL reset_out_tag got %h want 0", out_tag); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else passed++;
        @(negedge clk); rst_n = 1'b1; #1;
        total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_mul_basic();
        logic [31:0] r; logic [4:0] t; int lat;
        do_op(3'd0, 32'd2, 32'hFFFFFFFC, 5'd7, r, t, lat);
        total++; if (r !== 32'hFFFFFFF8) $display("FAIL mul_result got %h want fffffff8", r); else passed++;
        total++; if (t !== 5'd7) $display("FAIL mul_tag got %0d want 7", t); else passed++;
        total++; if (lat !== 34) $display("FAIL mul_latency got %0d want 34", lat); else passed++;
    endtask

    task automatic test_directed();
        logic [31:0] r; logic [4:0] t; int lat;
        for (int i = 0; i < 15; i++) begin
            do_op(DIR[i].op, DIR[i].a, DIR[i].b, 5'(i), r, t, lat);
            total++; if (r !== DIR[i].exp) $display("FAIL dir%0d_result got %h want %h", i, r, DIR[i].exp); else passed++;
            total++; if (lat !== int'(DIR[i].lat)) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, DIR[i].lat); else passed++;
        end
    endtask

    task automatic test_random();
        logic [31:0] r, x, y; logic [4:0] t, tg; logic [2:0] o; int lat, el;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom); x = pick(); y = pick(); tg = 5'($urandom);
            el = (o[2] && (y == 32'd0 || ((o == 3'd4 || o == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF))) ? 1 : 34;
            do_op(o, x, y, tg, r, t, lat);
            total++; if (r !== model(o, x, y)) $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h want %h", i, o, x, y, r, model(o, x, y)); else passed++;
            total++; if (t !== tg) $display("FAIL rnd%0d_tag got %0d want %0d", i, t, tg); else passed++;
            total++; if (lat !== el) $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, el); else passed++;
        end
    endtask

    task automatic test_backpressure();
        int n;
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; a = 32'd7; b = 32'd6; tag = 5'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (n < 100 && !out_valid) begin @(negedge clk); n++; end
        total++; if (out_valid !== 1'b1) $display("FAIL bp_timeout got %b want 1", out_valid); else passed++;
        repeat (5) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || result !== 32'd42 || out_tag !== 5'd3 || in_ready !== 1'b0)
                $display("FAIL bp_hold got v=%b r=%h t=%0d rdy=%b want v=1 r=2a t=3 rdy=0", out_valid, result, out_tag, in_ready);
            else passed++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); else passed++;
    endtask

    task automatic test_kill_busy();
        int seen;
        @(negedge clk);
        in_valid = 1'b1; op = 3'd4; a = 32'd100; b = 32'd7; tag = 5'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL kill_busy_idle got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy); else passed++;
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen++; end
        total++; if (seen !== 0) $display("FAIL kill_busy_no_result got %0d valid cycles want 0", seen); else passed++;
    endtask

    task automatic test_kill_idle();
        int seen;
        @(negedge clk);
        in_valid = 1'b1; kill = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5; tag = 5'd1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL kill_idle_state got rdy=%b busy=%b want rdy=1 busy=0", in_ready, busy); else passed++;
        seen = 0;
        repeat (40) begin @(negedge clk); if (out_valid) seen++; end
        total++; if (seen !== 0) $display("FAIL kill_idle_no_result got %0d valid cycles want 0", seen); else passed++;
    endtask

    task automatic test_async_reset();
        logic [31:0] r; logic [4:0] t; int lat;
        do_op(3'd0, 32'd5, 32'd5, 5'd2, r, t, lat);
        total++; if (r !== 32'd25) $display("FAIL ar_pre_result got %h want 19", r); else passed++;
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; a = 32'd11; b = 32'd13; tag = 5'd4;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || result !== 32'd0 || busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL ar_async got v=%b r=%h busy=%b rdy=%b want all 0", out_valid, result, busy, in_ready);
        else passed++;
        @(negedge clk); rst_n = 1'b1; #1;
        total++; if (in_ready !== 1'b1) $display("FAIL ar_release_in_ready got %b want 1", in_ready); else passed++;
        do_op(3'd0, 32'd3, 32'd3, 5'd5, r, t, lat);
        total++; if (r !== 32'd9) $display("FAIL ar_mul_result got %h want 9", r); else passed++;
        total++; if (lat !== 34) $display("FAIL ar_mul_latency got %0d want 34", lat); else passed++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mul_basic();
        test_directed();
        test_random();
        test_backpressure();
        test_kill_busy();
        test_kill_idle();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
